// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage MIPS core: latch/PC enables, stalls,
// flushes, halt drain and a saturating stall-cycle counter.
module hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_dmemREN,
    input  logic [4:0]       ex_wsel,
    input  logic             mem_dmem_req,
    input  logic             mem_halt,
    input  logic             ex_pc_redirect,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_stall,
    output logic             id_ex_flush,
    output logic             ex_mem_en,
    output logic             halted,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DWAIT  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   stall_count_q, stall_count_d;
    logic               load_use;
    logic               dwait;
    logic               freeze;

    assign load_use = ex_dmemREN && (ex_wsel != 5'd0) &&
                      ((ex_wsel == id_rs) || (id_uses_rt && (ex_wsel == id_rt)));
    assign dwait    = mem_dmem_req && !dhit;
    // In DWAIT the outstanding access is released only by dhit, regardless of req.
    assign freeze   = (state_q == DWAIT) ? !dhit : dwait;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q       <= RUN;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            stall_count_q <= stall_count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        if_id_flush = 1'b0;
        id_ex_stall = 1'b0;
        id_ex_flush = 1'b0;
        ex_mem_en   = 1'b1;

        if (state_q == HALTED || mem_halt) begin
            state_d     = HALTED;
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_stall = 1'b1;
            ex_mem_en   = 1'b0;
        end else if (freeze) begin
            state_d     = DWAIT;
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_stall = 1'b1;
            ex_mem_en   = 1'b0;
        end else begin
            state_d = RUN;
            // A redirect keeps pc_en high even on an imem miss so the target is taken.
            if (ex_pc_redirect) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (!ihit) begin
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                id_ex_stall = 1'b1;
            end else if (load_use) begin
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                id_ex_flush = 1'b1;
            end
        end
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if (!pc_en && state_q != HALTED && stall_count_q != {CNT_W{1'b1}}) begin
            stall_count_d = stall_count_q + 1'b1;
        end
    end

    assign halted      = (state_q == HALTED);
    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl, built with a 4-bit stall counter
// so saturation is reachable quickly.
module tb_hazard_ctrl;

    logic       CLK;
    logic       nRST;
    logic       ihit, dhit;
    logic [4:0] id_rs, id_rt, ex_wsel;
    logic       id_uses_rt, ex_dmemREN, mem_dmem_req, mem_halt, ex_pc_redirect;
    logic       pc_en, if_id_en, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_en;
    logic       halted;
    logic [3:0] stall_count;
    logic [5:0] ctl;

    int passed = 0;
    int checks = 0;

    // {pc_en, if_id_en, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_en}
    localparam logic [5:0] NOHAZ  = 6'b110001;
    localparam logic [5:0] FREEZE = 6'b000100;
    localparam logic [5:0] REDIR  = 6'b111011;
    localparam logic [5:0] MISS   = 6'b000101;
    localparam logic [5:0] LU     = 6'b000011;

    hazard_ctrl #(.CNT_W(4)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_dmemREN(ex_dmemREN), .ex_wsel(ex_wsel),
        .mem_dmem_req(mem_dmem_req), .mem_halt(mem_halt),
        .ex_pc_redirect(ex_pc_redirect),
        .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
        .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush),
        .ex_mem_en(ex_mem_en), .halted(halted), .stall_count(stall_count)
    );

    assign ctl = {pc_en, if_id_en, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_en};

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic set_idle();
        ihit = 1'b1; dhit = 1'b0; id_rs = 5'd1; id_rt = 5'd2; id_uses_rt = 1'b0;
        ex_dmemREN = 1'b0; ex_wsel = 5'd0; mem_dmem_req = 1'b0; mem_halt = 1'b0;
        ex_pc_redirect = 1'b0;
    endtask

    // Advance one clock and land 1 time unit after the rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        set_idle();
        nRST = 1'b0;
        #12;
        nRST = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        set_idle();
        nRST = 1'b0;
        #2;
        checks++; if (stall_count !== 4'd0) $display("[TB] FAIL reset_count: got %0d exp 0", stall_count); else passed++;
        checks++; if (halted !== 1'b0) $display("[TB] FAIL reset_halted: got %b exp 0", halted); else passed++;
        checks++; if (ctl !== NOHAZ) $display("[TB] FAIL reset_ctl: got %b exp %b", ctl, NOHAZ); else passed++;
        #10;
        nRST = 1'b1;
        tick();
    endtask

    task automatic test_load_use();
        do_reset();
        ex_dmemREN = 1'b1; ex_wsel = 5'd3; id_rs = 5'd3; #1;
        checks++; if (ctl !== LU) $display("[TB] FAIL lu_stall: got %b exp %b", ctl, LU); else passed++;
        tick();
        ex_dmemREN = 1'b0; ex_wsel = 5'd0; #1;
        checks++; if (ctl !== NOHAZ) $display("[TB] FAIL lu_release: got %b exp %b", ctl, NOHAZ); else passed++;
        checks++; if (stall_count !== 4'd1) $display("[TB] FAIL lu_count: got %0d exp 1", stall_count); else passed++;
        tick();
    endtask

    task automatic test_load_use_exempt();
        do_reset();
        ex_dmemREN = 1'b1; ex_wsel = 5'd0; id_rs = 5'd0; #1;
        checks++; if (ctl !== NOHAZ) $display("[TB] FAIL lu_r0: got %b exp %b", ctl, NOHAZ); else passed++;
        tick();
        ex_wsel = 5'd5; id_rs = 5'd2; id_rt = 5'd5; id_uses_rt = 1'b0; #1;
        checks++; if (ctl !== NOHAZ) $display("[TB] FAIL lu_rt_unused: got %b exp %b", ctl, NOHAZ); else passed++;
        tick();
        checks++; if (stall_count !== 4'd0) $display("[TB] FAIL lu_exempt_count: got %0d exp 0", stall_count); else passed++;
        id_uses_rt = 1'b1; #1;
        checks++; if (ctl !== LU) $display("[TB] FAIL lu_rt_used: got %b exp %b", ctl, LU); else passed++;
        tick();
        set_idle();
    endtask

    task automatic test_dmem_wait();
        do_reset();
        mem_dmem_req = 1'b1; dhit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (ctl !== FREEZE) $display("[TB] FAIL dwait_freeze%0d: got %b exp %b", i, ctl, FREEZE); else passed++;
            tick();
            mem_dmem_req = (i == 0) ? 1'b0 : 1'b1;
        end
        dhit = 1'b1; #1;
        checks++; if (ctl !== NOHAZ) $display("[TB] FAIL dwait_release: got %b exp %b", ctl, NOHAZ); else passed++;
        tick();
        mem_dmem_req = 1'b0; dhit = 1'b0; #1;
        checks++; if (ctl !== NOHAZ) $display("[TB] FAIL dwait_back_run: got %b exp %b", ctl, NOHAZ); else passed++;
        checks++; if (stall_count !== 4'd3) $display("[TB] FAIL dwait_count: got %0d exp 3", stall_count); else passed++;
    endtask

    task automatic test_priority();
        do_reset();
        mem_dmem_req = 1'b1; dhit = 1'b0; ex_pc_redirect = 1'b1;
        ex_dmemREN = 1'b1; ex_wsel = 5'd7; id_rs = 5'd7; #1;
        checks++; if (ctl !== FREEZE) $display("[TB] FAIL prio_freeze: got %b exp %b", ctl, FREEZE); else passed++;
        tick();
        dhit = 1'b1; #1;
        checks++; if (ctl !== REDIR) $display("[TB] FAIL prio_release_redir: got %b exp %b", ctl, REDIR); else passed++;
        tick();
        mem_dmem_req = 1'b0; dhit = 1'b0; ihit = 1'b0; #1;
        checks++; if (ctl !== REDIR) $display("[TB] FAIL prio_redir_over_miss: got %b exp %b", ctl, REDIR); else passed++;
        ex_pc_redirect = 1'b0; #1;
        checks++; if (ctl !== MISS) $display("[TB] FAIL prio_miss_over_lu: got %b exp %b", ctl, MISS); else passed++;
        tick();
        set_idle();
    endtask

    task automatic test_halt();
        do_reset();
        mem_halt = 1'b1; #1;
        checks++; if (ctl !== FREEZE) $display("[TB] FAIL halt_entry_ctl: got %b exp %b", ctl, FREEZE); else passed++;
        checks++; if (halted !== 1'b0) $display("[TB] FAIL halt_entry_flag: got %b exp 0", halted); else passed++;
        tick();
        mem_halt = 1'b0;
        for (int i = 0; i < 12; i++) begin
            ihit = i[0]; ex_pc_redirect = i[1]; mem_dmem_req = i[2]; dhit = ~i[0]; #1;
            checks++; if (halted !== 1'b1) $display("[TB] FAIL halt_held%0d: got %b exp 1", i, halted); else passed++;
            checks++; if (ctl !== FREEZE) $display("[TB] FAIL halt_ctl%0d: got %b exp %b", i, ctl, FREEZE); else passed++;
            tick();
        end
        checks++; if (stall_count !== 4'd1) $display("[TB] FAIL halt_count: got %0d exp 1", stall_count); else passed++;
        // Asynchronous reset out of HALTED, between edges.
        set_idle(); #2;
        nRST = 1'b0; #1;
        checks++; if (halted !== 1'b0) $display("[TB] FAIL halt_reset_flag: got %b exp 0", halted); else passed++;
        checks++; if (ctl !== NOHAZ) $display("[TB] FAIL halt_reset_ctl: got %b exp %b", ctl, NOHAZ); else passed++;
        #10;
        nRST = 1'b1;
    endtask

    task automatic test_saturation_reset();
        do_reset();
        ihit = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        checks++; if (stall_count !== 4'd15) $display("[TB] FAIL sat_count: got %0d exp 15", stall_count); else passed++;
        ihit = 1'b1; mem_dmem_req = 1'b1; dhit = 1'b0;
        tick();
        tick();
        checks++; if (stall_count !== 4'd15) $display("[TB] FAIL sat_hold: got %0d exp 15", stall_count); else passed++;
        // Now in DWAIT: drop the request so only the state keeps the freeze alive.
        mem_dmem_req = 1'b0; #1;
        checks++; if (ctl !== FREEZE) $display("[TB] FAIL dwait_state_freeze: got %b exp %b", ctl, FREEZE); else passed++;
        #1;
        nRST = 1'b0; #1;
        checks++; if (stall_count !== 4'd0) $display("[TB] FAIL async_reset_count: got %0d exp 0", stall_count); else passed++;
        checks++; if (halted !== 1'b0) $display("[TB] FAIL async_reset_halted: got %b exp 0", halted); else passed++;
        checks++; if (ctl !== NOHAZ) $display("[TB] FAIL async_reset_run: got %b exp %b", ctl, NOHAZ); else passed++;
        #10;
        nRST = 1'b1;
        tick();
    endtask

    initial begin
        set_idle();
        nRST = 1'b1;
        test_reset();
        test_load_use();
        test_load_use_exempt();
        test_dmem_wait();
        test_priority();
        test_halt();
        test_saturation_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline control block for the 5-stage MIPS core.
- Computes the stall, flush and enable signals consumed by the IF/ID, ID/EX and EX/MEM latches and by the PC register, so this block is the driving end of the latches' stall and enable inputs.
- Handles load-use hazards, taken branches and jumps, instruction-fetch misses, data-memory waits and halt drain.
- Keeps a saturating count of stall cycles for performance debug.

Parameters:
- CNT_W, 16, width of the stall_count saturating counter.

Ports:
- CLK  input  1  system clock, rising edge
- nRST  input  1  asynchronous reset, active low
- ihit  input  1  instruction fetch complete this cycle
- dhit  input  1  data access complete this cycle
- id_rs  input  5  rs field of the instruction in ID
- id_rt  input  5  rt field of the instruction in ID
- id_uses_rt  input  1  ID instruction reads rt as a source (R-type, beq/bne, sw)
- ex_dmemREN  input  1  instruction in EX is a load
- ex_wsel  input  5  destination register of the instruction in EX
- mem_dmem_req  input  1  instruction in MEM requests dmem (REN|WEN)
- mem_halt  input  1  halt instruction has reached MEM
- ex_pc_redirect  input  1  taken branch or jump resolved in EX
- pc_en  output  1  PC register load enable
- if_id_en  output  1  IF/ID latch enable
- if_id_flush  output  1  IF/ID latch loads a bubble
- id_ex_stall  output  1  ID/EX latch holds its value
- id_ex_flush  output  1  ID/EX latch loads a bubble
- ex_mem_en  output  1  EX/MEM and MEM/WB latch enable
- halted  output  1  pipeline is permanently frozen
- stall_count  output  CNT_W  saturating count of cycles with pc_en=0 while not halted

Behaviour:
- FSM states: RUN, DWAIT, HALTED. Reset state is RUN.
- Reset values: stall_count=0, halted=0. The control outputs are combinational from state and inputs, so during reset they take their RUN-state values for the current inputs.
- Signal definitions:
  - load_use = ex_dmemREN & (ex_wsel!=0) & ((ex_wsel==id_rs) | (id_uses_rt & ex_wsel==id_rt)).
  - dwait = mem_dmem_req & ~dhit.
- Output priority in RUN and DWAIT, highest first:
  1. halt
  2. dmem freeze
  3. redirect
  4. imem miss
  5. load-use
- HALTED (and RUN with mem_halt=1):
  - pc_en=if_id_en=ex_mem_en=0, id_ex_stall=1, flushes 0.
  - halted=1 from the cycle after entry.
  - Only reset exits HALTED.
- dmem freeze (state DWAIT, or RUN with dwait=1):
  - pc_en=if_id_en=ex_mem_en=0, id_ex_stall=1, no flushes.
  - RUN->DWAIT when dwait=1.
  - DWAIT->RUN on the first cycle with dhit=1. During that cycle all stages advance (same as RUN with no hazard).
- redirect (ex_pc_redirect=1 and no freeze):
  - if_id_flush=1, id_ex_flush=1, pc_en=1, ex_mem_en=1.
  - This overrides load_use and an ihit=0 condition in the same cycle.
  - If ihit=0, pc_en stays 1 so the PC takes the redirect target.
- imem miss (ihit=0, none of the above):
  - pc_en=0, if_id_en=0, id_ex_stall=1, ex_mem_en=1.
  - Downstream stages drain; no new instruction enters ID/EX.
- load-use (ihit=1, load_use=1, none of the above):
  - pc_en=0, if_id_en=0, id_ex_flush=1 (bubble), ex_mem_en=1.
  - The bubble removes the load from EX, so the stall lasts exactly 1 cycle.
- No hazard: pc_en=if_id_en=ex_mem_en=1, all stall and flush outputs 0.
- id_ex_stall and id_ex_flush are never asserted together. Flush wins where both would apply.
- stall_count increments on each rising edge where pc_en=0 and state!=HALTED. It saturates at 2^CNT_W-1 and never wraps.
- Asynchronous reset mid-DWAIT or mid-HALTED returns to RUN and clears the counter immediately.

Test Plan:
- Load-use: lw $3 in EX (ex_dmemREN=1, ex_wsel=3), id_rs=3, ihit=1 -> one cycle of pc_en=0, id_ex_flush=1; next cycle all enables 1; stall_count=1.
- Load-use with $0 or with a non-reading rt: ex_wsel=0, or id_rt=ex_wsel with id_uses_rt=0 -> no stall, stall_count unchanged.
- Dmem wait: mem_dmem_req=1, dhit=0 for 3 cycles then 1 -> freeze for 3 cycles, advance on the 4th, state back to RUN, stall_count=3.
- Priority: dwait=1, ex_pc_redirect=1 and load_use=1 together -> freeze only, no flushes. On release with redirect still high -> if_id_flush=id_ex_flush=1.
- Halt: mem_halt=1 -> all enables 0 that cycle, halted=1 next cycle and held for 10+ cycles regardless of inputs; stall_count does not increment once halted=1.
- Saturation and reset: CNT_W=4, 20 consecutive ihit=0 cycles -> stall_count holds at 15. Assert nRST low mid-DWAIT -> stall_count=0, halted=0, state RUN without waiting for a clock edge.
